spi_master: RTL and testbench



---
 rtl/spi_pkg.sv | 8 +
 rtl/spi_sclk_gen.sv | 38 +++
 rtl/spi_master.sv | 129 ++++++++++++
 tb/tb_spi_master.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: SPI controller state encoding and frame width shared with the SPI slave
package spi_pkg;

    localparam int SPI_DATA_WIDTH = 16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_master_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk into a CPOL=0 sclk and flags the clk edge on which sclk rises or falls
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise_en,
    output logic fall_en
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap    = cnt == CW'(CLK_DIV - 1);
    assign rise_en = en && wrap && !sclk;
    assign fall_en = en && wrap && sclk;

    // While disabled the counter is parked at terminal count so sclk rises on the first enabled cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= CW'(CLK_DIV - 1);
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= CW'(CLK_DIV - 1);
            sclk <= 1'b0;
        end else if (wrap) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master.sv
// spi_master: full-duplex SPI controller, mode 0, MSB first; `SPI_MASTER_LOOPBACK_EN feeds mosi back into the rx shifter
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 4,
    parameter int CS_SETUP   = 2,
    parameter int CS_HOLD    = 2,
    parameter int IDLE_GAP   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs_bar
);

    localparam int BW = $clog2(DATA_WIDTH) + 1;

    spi_master_state_t     state;
    logic [15:0]           cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  sclk_en;
    logic                  rise_en;
    logic                  fall_en;
    logic                  rx_bit;

    // Enabling the divider in the last SETUP cycle makes the first rise land exactly CS_SETUP cycles after cs_bar falls
    assign sclk_en = state == SHIFT || (state == SETUP && cnt == 16'(CS_SETUP - 1));

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = mosi;
`else
    assign rx_bit = miso;
`endif

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk    (clk),
        .reset  (reset),
        .en     (sclk_en),
        .sclk   (sclk),
        .rise_en(rise_en),
        .fall_en(fall_en)
    );

    // Frame sequencer: chip-select framing, shifting on sclk strobes, result hand-off
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            mosi     <= 1'b0;
            cs_bar   <= 1'b1;
            tx_ready <= 1'b1;
            busy     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (rise_en) begin
                mosi  <= tx_sr[DATA_WIDTH-1];
                tx_sr <= tx_sr << 1;
            end
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_sr    <= tx_data;
                        cnt      <= '0;
                        bit_cnt  <= '0;
                        cs_bar   <= 1'b0;
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 16'(CS_SETUP - 1)) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (fall_en) begin
                        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], rx_bit};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_WIDTH - 1)) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt == 16'(CS_HOLD - 1)) begin
                        cnt      <= '0;
                        cs_bar   <= 1'b1;
                        rx_data  <= rx_sr;
                        rx_valid <= 1'b1;
                        mosi     <= 1'b0;
                        state    <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == 16'(IDLE_GAP - 1)) begin
                        cnt      <= '0;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master framing, timing and data against a bench SPI slave model
module tb_spi_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] tx_data = 16'h0000;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso = 1'b0;
    logic        cs_bar;

    int checks = 0;
    int errors = 0;

    logic [15:0] slave_tx = 16'h0000;
    logic [15:0] slave_sh = 16'h0000;
    logic [15:0] slave_rx = 16'h0000;

    spi_master #(
        .DATA_WIDTH(16),
        .CLK_DIV   (4),
        .CS_SETUP  (2),
        .CS_HOLD   (2),
        .IDLE_GAP  (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .busy    (busy),
        .sclk    (sclk),
        .mosi    (mosi),
        .miso    (miso),
        .cs_bar  (cs_bar)
    );

    always #5 clk = ~clk;

    // Slave model: loads its reply when selected, drives miso on sclk rise, samples mosi on sclk fall
    always @(negedge cs_bar or posedge sclk) begin
        if (sclk) begin
            miso = slave_sh[15];
            slave_sh = {slave_sh[14:0], 1'b0};
        end else begin
            slave_sh = slave_tx;
        end
    end

    always @(negedge sclk) if (!cs_bar) slave_rx = {slave_rx[14:0], mosi};

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [15:0] exp_rx(input logic [15:0] sent, input logic [15:0] reply);
`ifdef SPI_MASTER_LOOPBACK_EN
        return sent;
`else
        return reply;
`endif
    endfunction

    // Sends one word and records timing; cycle 1 is the first cycle after acceptance, -1 means never seen
    task automatic run_frame(input logic [15:0] w, input int inject_at, output int cs1, output int rise_c,
                             output int rv_c, output int rdy_c, output int pulses, output logic [15:0] mosi_w);
        logic prev_sclk;
        rise_c = -1; rv_c = -1; rdy_c = -1; pulses = 0; mosi_w = 16'h0000;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
        tx_data = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        cs1 = cs_bar ? 1 : 0;
        prev_sclk = 1'b0;
        for (int cyc = 1; cyc < 400; cyc++) begin
            if (sclk && !prev_sclk) begin
                if (rise_c < 0) rise_c = cyc;
                mosi_w = {mosi_w[14:0], mosi};
            end
            prev_sclk = sclk;
            if (rx_valid) begin
                pulses++;
                if (rv_c < 0) rv_c = cyc;
            end
            if (tx_ready) begin
                rdy_c = cyc;
                break;
            end
            if (cyc == inject_at) begin
                tx_data = 16'h0000;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
        checks++; if (cs_bar !== 1'b1) begin errors++; $display("FAIL reset_cs_bar: got %b expected 1", cs_bar); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame;
        int cs1, rise_c, rv_c, rdy_c, pulses;
        logic [15:0] mw;
        slave_tx = 16'h3C5A;
        run_frame(16'hA5C3, 0, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        checks++; if (cs1 !== 0) begin errors++; $display("FAIL single_cs_low_cycle1: got %0d expected 0", cs1); end
        checks++; if (rise_c !== 3) begin errors++; $display("FAIL single_first_rise: got cycle %0d expected 3", rise_c); end
        checks++; if (rv_c !== 129) begin errors++; $display("FAIL single_rx_valid_cycle: got %0d expected 129", rv_c); end
        checks++; if (rdy_c !== 131) begin errors++; $display("FAIL single_tx_ready_cycle: got %0d expected 131", rdy_c); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL single_rx_valid_width: got %0d expected 1", pulses); end
        checks++; if (mw !== 16'hA5C3) begin errors++; $display("FAIL single_mosi_on_rise: got %h expected a5c3", mw); end
        checks++; if (slave_rx !== 16'hA5C3) begin errors++; $display("FAIL single_slave_rx: got %h expected a5c3", slave_rx); end
        checks++; if (rx_data !== exp_rx(16'hA5C3, 16'h3C5A)) begin errors++; $display("FAIL single_rx_data: got %h expected %h", rx_data, exp_rx(16'hA5C3, 16'h3C5A)); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL single_mosi_idle: got %b expected 0", mosi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
        checks++; if (cs_bar !== 1'b1) begin errors++; $display("FAIL single_cs_idle: got %b expected 1", cs_bar); end
    endtask

    task automatic test_ignored_request;
        int cs1, rise_c, rv_c, rdy_c, pulses, lows;
        logic [15:0] mw;
        slave_tx = 16'h0F0F;
        run_frame(16'hBEEF, 40, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        lows = 0;
        repeat (20) begin
            @(negedge clk);
            if (!cs_bar) lows++;
        end
        checks++; if (rv_c !== 129) begin errors++; $display("FAIL ignored_rx_valid_cycle: got %0d expected 129", rv_c); end
        checks++; if (slave_rx !== 16'hBEEF) begin errors++; $display("FAIL ignored_latched_word: got %h expected beef", slave_rx); end
        checks++; if (rx_data !== exp_rx(16'hBEEF, 16'h0F0F)) begin errors++; $display("FAIL ignored_rx_data: got %h expected %h", rx_data, exp_rx(16'hBEEF, 16'h0F0F)); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL ignored_extra_frame: got %0d selected cycles expected 0", lows); end
    endtask

    task automatic test_back_to_back;
        int pulses, frames, gap, gap_len, lows;
        logic prev_cs;
        logic [15:0] rx1;
        pulses = 0; frames = 0; gap = 0; gap_len = -1; lows = 0; prev_cs = 1'b1; rx1 = 16'h0000;
        slave_tx = 16'hC001;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
        tx_data = 16'h1111;
        tx_valid = 1'b1;
        for (int c = 0; c < 600 && pulses < 2; c++) begin
            @(negedge clk);
            if (!cs_bar && prev_cs) begin
                frames++;
                if (frames == 1) tx_data = 16'h2222;
                else begin
                    tx_valid = 1'b0;
                    gap_len = gap;
                end
            end
            if (cs_bar && frames == 1) gap++;
            if (rx_valid) begin
                pulses++;
                if (pulses == 1) begin
                    rx1 = rx_data;
                    slave_tx = 16'h0BAD;
                end
            end
            prev_cs = cs_bar;
        end
        tx_valid = 1'b0;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
        repeat (20) begin
            @(negedge clk);
            if (!cs_bar) lows++;
        end
        checks++; if (frames !== 2) begin errors++; $display("FAIL b2b_frames: got %0d expected 2", frames); end
        checks++; if (gap_len !== 3) begin errors++; $display("FAIL b2b_cs_gap: got %0d cycles expected 3", gap_len); end
        checks++; if (pulses !== 2) begin errors++; $display("FAIL b2b_rx_valid_pulses: got %0d expected 2", pulses); end
        checks++; if (rx1 !== exp_rx(16'h1111, 16'hC001)) begin errors++; $display("FAIL b2b_rx_first: got %h expected %h", rx1, exp_rx(16'h1111, 16'hC001)); end
        checks++; if (rx_data !== exp_rx(16'h2222, 16'h0BAD)) begin errors++; $display("FAIL b2b_rx_second: got %h expected %h", rx_data, exp_rx(16'h2222, 16'h0BAD)); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL b2b_third_frame: got %0d selected cycles expected 0", lows); end
    endtask

    task automatic test_echo_slave;
        int cs1, rise_c, rv_c, rdy_c, pulses;
        logic [15:0] mw;
        slave_tx = 16'h5555;
        run_frame(16'h1234, 0, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        slave_tx = slave_rx;
        run_frame(16'h0000, 0, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        checks++; if (rx_data !== exp_rx(16'h0000, 16'h1234)) begin errors++; $display("FAIL echo_rx_data: got %h expected %h", rx_data, exp_rx(16'h0000, 16'h1234)); end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL echo_rx_valid_width: got %0d expected 1", pulses); end
    endtask

`ifdef SPI_MASTER_LOOPBACK_EN
    task automatic test_loopback;
        int cs1, rise_c, rv_c, rdy_c, pulses;
        logic [15:0] mw;
        slave_tx = 16'h0000;
        run_frame(16'hFFFF, 0, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        checks++; if (rx_data !== 16'hFFFF) begin errors++; $display("FAIL loopback_ffff: got %h expected ffff", rx_data); end
        run_frame(16'h0001, 0, cs1, rise_c, rv_c, rdy_c, pulses, mw);
        checks++; if (rx_data !== 16'h0001) begin errors++; $display("FAIL loopback_0001: got %h expected 0001", rx_data); end
    endtask
`endif

    task automatic test_reset_mid_frame;
        int rises, valids, lows;
        logic prev;
        rises = 0; valids = 0; lows = 0; prev = 1'b0;
        slave_tx = 16'hFFFF;
        for (int i = 0; i < 50 && !tx_ready; i++) @(negedge clk);
        tx_data = 16'h1357;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (sclk && !prev) rises++;
            prev = sclk;
            if (rises == 5) break;
            @(negedge clk);
        end
        checks++; if (rises !== 5) begin errors++; $display("FAIL midreset_reach_edge5: got %0d rises expected 5", rises); end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (cs_bar !== 1'b1) begin errors++; $display("FAIL midreset_cs_bar: got %b expected 1", cs_bar); end
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk: got %b expected 0", sclk); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL midreset_mosi: got %b expected 0", mosi); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (rx_valid) valids++;
            if (!cs_bar) lows++;
        end
        checks++; if (valids !== 0) begin errors++; $display("FAIL midreset_rx_valid: got %0d pulses expected 0", valids); end
        checks++; if (lows !== 0) begin errors++; $display("FAIL midreset_cs_after: got %0d selected cycles expected 0", lows); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL midreset_tx_ready: got %b expected 1", tx_ready); end
        checks++; if (rx_data !== 16'h0000) begin errors++; $display("FAIL midreset_rx_data: got %h expected 0000", rx_data); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_ignored_request();
        test_back_to_back();
        test_echo_slave();
`ifdef SPI_MASTER_LOOPBACK_EN
        test_loopback();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
